// File: rtl/vga_fb_arbiter_if.sv
// Writer request/ack and framebuffer RAM bus shared by vga_fb_arbiter.
// The master modport is the arbiter side; the slave modport is the writer/RAM side.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic [23:0]       mem_rdata;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: raster-order prefetch into a FWFT FIFO for VGA scan-out,
// writer accesses in spare slots. Optional underrun counter enabled by VGA_FB_UNDERRUN_CNT_EN.
module vga_fb_arbiter #(
  parameter int unsigned H_VALID    = 640,
  parameter int unsigned V_VALID    = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WM     = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        valid,
  output logic [23:0] vga_data,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  vga_fb_arbiter_if.master bus
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned NPIX  = H_VALID * V_VALID;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic              vsync_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;
  logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [LVL_W-1:0]  count;

  logic              vsync_rise;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              rd_ok;
  logic              rd_issue;
  logic              wr_grant;
  logic              push;
  logic              pop;

  // Arbitration: display reads win below the low watermark, otherwise the writer goes first.
  always_comb begin
    vsync_rise = vsync & ~vsync_q;
    empty      = (count == '0);
    level      = count + LVL_W'(inflight);
    rd_ok      = !reset && !vsync_rise && (level < LVL_W'(FIFO_DEPTH));
    rd_issue   = 1'b0;
    wr_grant   = 1'b0;
    if (rd_ok && (level < LVL_W'(LOW_WM))) begin
      rd_issue = 1'b1;
    end else if (!reset && bus.wr_req) begin
      wr_grant = 1'b1;
    end else if (rd_ok) begin
      rd_issue = 1'b1;
    end
    push = inflight && !vsync_rise;
    pop  = valid && !empty;
  end

  // RAM port and writer ack follow the grant in the same cycle.
  always_comb begin
    bus.mem_en    = rd_issue | wr_grant;
    bus.mem_we    = wr_grant;
    bus.wr_ack    = wr_grant;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (wr_grant) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
    end else if (rd_issue) begin
      bus.mem_addr = rd_ptr;
    end
  end

  // First-word-fall-through head; no bypass of a same-cycle push.
  always_comb begin
    vga_data = '0;
    if (!empty) begin
      vga_data = fifo_mem[head];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      underrun <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      inflight <= rd_issue;
      if (vsync_rise) begin
        rd_ptr <= '0;
      end else if (rd_issue) begin
        rd_ptr <= (rd_ptr == ADDR_W'(NPIX - 1)) ? '0 : rd_ptr + ADDR_W'(1);
      end
      // Frame start drops everything prefetched, including the read still returning.
      if (vsync_rise) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        count <= count + LVL_W'(push) - LVL_W'(pop);
      end
      if (valid && empty) begin
        underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset && push) begin
      fifo_mem[tail] <= bus.mem_rdata;
    end
  end

`ifdef VGA_FB_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt;

  // Saturating per-frame count of empty-pop cycles.
  always_ff @(posedge pclk) begin
    if (reset || vsync_rise) begin
      ur_cnt <= '0;
    end else if (valid && empty && (ur_cnt != 16'hFFFF)) begin
      ur_cnt <= ur_cnt + 16'd1;
    end
  end

  assign underrun_cnt = ur_cnt;
`else
  assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter on a reduced 16x4 frame.
// Expected underrun_cnt depends on whether VGA_FB_UNDERRUN_CNT_EN is defined.
module tb_vga_fb_arbiter;

  localparam int unsigned H  = 16;
  localparam int unsigned V  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned NP = H * V;

`ifdef VGA_FB_UNDERRUN_CNT_EN
  localparam logic [31:0] UR_EXP = 32'd2;
`else
  localparam logic [31:0] UR_EXP = 32'd0;
`endif

  logic        pclk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        valid;
  logic [23:0] vga_data;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic [23:0] ram [NP];
  int          tests;
  int          fails;
  int          px;

  vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();

  vga_fb_arbiter #(
    .H_VALID(H), .V_VALID(V), .ADDR_W(AW), .FIFO_DEPTH(16), .LOW_WM(4)
  ) dut (
    .pclk(pclk), .reset(reset), .vsync(vsync), .valid(valid),
    .vga_data(vga_data), .underrun(underrun), .underrun_cnt(underrun_cnt),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  // Framebuffer RAM with one-cycle read latency.
  always @(posedge pclk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  function automatic logic [23:0] pix(input int a);
    return 24'h000100 + 24'(a % NP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; px = 0;
    reset = 1'b1; vsync = 1'b0; valid = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.mem_rdata = '0;
    for (int a = 0; a < int'(NP); a++) ram[a] = pix(a);

    // Reset state
    tick(); tick();
    #1;
    chk("rst_vga_data", 32'(vga_data), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_underrun_cnt", 32'(underrun_cnt), 32'h0);
    bus.wr_req = 1'b1;
    #1;
    chk("rst_no_ack", 32'(bus.wr_ack), 32'h0);
    bus.wr_req = 1'b0;
    tick();
    reset = 1'b0;

    // Fill: reads 0..15 back to back, then idle with the FIFO full
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fill_en", 32'(bus.mem_en), 32'h1);
      chk("fill_we", 32'(bus.mem_we), 32'h0);
      chk("fill_addr", 32'(bus.mem_addr), 32'(i));
      if (i == 1) chk("lat_empty", 32'(vga_data), 32'h0);
      if (i == 2) chk("lat_head", 32'(vga_data), 32'(pix(0)));
      tick();
    end
    #1; chk("full_idle0", 32'(bus.mem_en), 32'h0); tick();
    #1; chk("full_idle1", 32'(bus.mem_en), 32'h0); tick();
    #1; chk("full_idle2", 32'(bus.mem_en), 32'h0);
    chk("full_head", 32'(vga_data), 32'(pix(0)));
    tick();

    // Streaming across the frame wrap (64 pixels per frame)
    for (int j = 0; j < 80; j++) begin
      valid = 1'b1;
      #1;
      chk("stream_data", 32'(vga_data), 32'(pix(px)));
      px++;
      tick();
    end
    valid = 1'b0;
    repeat (5) tick();
    #1; chk("stream_no_underrun", 32'(underrun), 32'h0);
    tick();

    // Writer vs display priority around the low watermark
    bus.wr_req = 1'b1; bus.wr_addr = 6'd60; bus.wr_data = 24'hFF0000;
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1;
      #1;
      chk("wr_hi_ack", 32'(bus.wr_ack), 32'h1);
      chk("wr_hi_data", 32'(vga_data), 32'(pix(px)));
      px++;
      tick();
    end
    valid = 1'b0;
    #1;
    chk("wr_l10_ack", 32'(bus.wr_ack), 32'h1);
    chk("wr_l10_en", 32'(bus.mem_en), 32'h1);
    chk("wr_l10_we", 32'(bus.mem_we), 32'h1);
    chk("wr_l10_addr", 32'(bus.mem_addr), 32'd60);
    chk("wr_l10_wdata", 32'(bus.mem_wdata), 32'hFF0000);
    tick();
    for (int k = 0; k < 7; k++) begin
      valid = 1'b1;
      #1;
      chk("wr_mid_ack", 32'(bus.wr_ack), 32'h1);
      chk("wr_mid_data", 32'(vga_data), 32'(pix(px)));
      px++;
      tick();
    end
    valid = 1'b0;
    #1;
    chk("wr_l3_ack", 32'(bus.wr_ack), 32'h0);
    chk("wr_l3_we", 32'(bus.mem_we), 32'h0);
    chk("wr_l3_en", 32'(bus.mem_en), 32'h1);
    chk("wr_l3_rdaddr", 32'(bus.mem_addr), 32'd32);
    tick();
    #1; chk("wr_l4_ack", 32'(bus.wr_ack), 32'h1);
    tick();
    bus.wr_req = 1'b0;
    #1; chk("rd_after_wr", 32'(bus.mem_addr), 32'd33);
    chk("rd_after_wr_en", 32'(bus.mem_en), 32'h1);
    tick();

    // vsync rise with a read in flight
    vsync = 1'b1;
    #1; chk("vs_edge_no_read", 32'(bus.mem_en), 32'h0);
    tick();
    #1; chk("vs_flushed", 32'(vga_data), 32'h0);
    chk("vs_rd0_en", 32'(bus.mem_en), 32'h1);
    chk("vs_rd0_addr", 32'(bus.mem_addr), 32'h0);
    tick();
    #1; chk("vs_drop_inflight", 32'(vga_data), 32'h0);
    chk("vs_rd1_addr", 32'(bus.mem_addr), 32'h1);
    tick();
    #1; chk("vs_new_head", 32'(vga_data), 32'(pix(0)));
    tick();
    vsync = 1'b0;
    repeat (20) tick();
    #1; chk("vs_no_underrun", 32'(underrun), 32'h0);
    tick();

    // Underrun: valid held from reset
    reset = 1'b1; valid = 1'b1;
    tick();
    reset = 1'b0;
    #1; chk("ur_c0_data", 32'(vga_data), 32'h0);
    chk("ur_c0_addr", 32'(bus.mem_addr), 32'h0);
    chk("ur_c0_flag", 32'(underrun), 32'h0);
    tick();
    #1; chk("ur_c1_flag", 32'(underrun), 32'h1);
    chk("ur_c1_data", 32'(vga_data), 32'h0);
    tick();
    #1; chk("ur_c2_data", 32'(vga_data), 32'(pix(0)));
    tick();
    #1; chk("ur_c3_data", 32'(vga_data), 32'(pix(1)));
    tick();
    valid = 1'b0;
    #1; chk("ur_cnt", 32'(underrun_cnt), UR_EXP);
    tick();
    vsync = 1'b1;
    tick();
    #1; chk("ur_cnt_vs_clear", 32'(underrun_cnt), 32'h0);
    chk("ur_sticky", 32'(underrun), 32'h1);
    chk("ur_vs_rd_addr", 32'(bus.mem_addr), 32'h0);
    chk("ur_vs_rd_en", 32'(bus.mem_en), 32'h1);
    tick();
    vsync = 1'b0;

    // Reset with a read in flight and a pending write
    reset = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 24'h123456;
    #1; chk("mrst_ack", 32'(bus.wr_ack), 32'h0);
    chk("mrst_en", 32'(bus.mem_en), 32'h0);
    chk("mrst_we", 32'(bus.mem_we), 32'h0);
    tick();
    reset = 1'b0;
    #1; chk("mrst_r0_data", 32'(vga_data), 32'h0);
    chk("mrst_r0_underrun", 32'(underrun), 32'h0);
    chk("mrst_r0_cnt", 32'(underrun_cnt), 32'h0);
    chk("mrst_r0_ack", 32'(bus.wr_ack), 32'h0);
    chk("mrst_r0_addr", 32'(bus.mem_addr), 32'h0);
    tick();
    #1; chk("mrst_stale_dropped", 32'(vga_data), 32'h0);
    chk("mrst_r1_ack", 32'(bus.wr_ack), 32'h0);
    tick();
    bus.wr_req = 1'b0;
    #1; chk("mrst_r2_head", 32'(vga_data), 32'(pix(0)));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
